// File: rtl/ir_key_filter.sv
// ir_key_filter: checks decoded NEC frames and turns them into key press,
// repeat and release events with a hold timeout.
//
// state | meaning
// IDLE  | no key held, waiting for the first good frame
// HELD  | key held, hold timer counting down to release
module ir_key_filter #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int HOLD_MS  = 120,
   parameter int CHK_ADDR = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ir_data,
   input  logic        ir_data_vld,
   output logic [7:0]  key_addr,
   output logic [7:0]  key_cmd,
   output logic        key_vld,
   output logic        key_rpt,
   output logic        key_rel,
   output logic        key_hold,
   output logic [7:0]  rpt_cnt,
   output logic [7:0]  err_cnt
);

   localparam int TMO = CLK_FREQ / 1000 * HOLD_MS;
   localparam int TW  = (TMO > 1) ? $clog2(TMO) : 1;
   localparam logic [TW-1:0] TMO_LD = TW'(TMO - 1);

   typedef enum logic {IDLE, HELD} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [7:0]      addr_d, cmd_d, rpt_cnt_d, err_cnt_d;
   logic            vld_d, rpt_d, rel_d;

   logic [7:0] f_addr, f_naddr, f_cmd, f_ncmd;
   logic       addr_ok, frame_good, frame_bad, same_key, tmr_tc;

   assign f_addr     = ir_data[7:0];
   assign f_naddr    = ir_data[15:8];
   assign f_cmd      = ir_data[23:16];
   assign f_ncmd     = ir_data[31:24];
   assign addr_ok    = (CHK_ADDR == 0) || (f_addr == ~f_naddr);
   assign frame_good = ir_data_vld && (f_cmd == ~f_ncmd) && addr_ok;
   assign frame_bad  = ir_data_vld && !frame_good;
   assign same_key   = (f_addr == key_addr) && (f_cmd == key_cmd);
   assign tmr_tc     = (tmr_q == '0);

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      addr_d    = key_addr;
      cmd_d     = key_cmd;
      rpt_cnt_d = rpt_cnt;
      vld_d     = 1'b0;
      rpt_d     = 1'b0;
      rel_d     = 1'b0;
      err_cnt_d = (frame_bad && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;

      case (state_q)
         IDLE: begin
            if (frame_good) begin
               addr_d    = f_addr;
               cmd_d     = f_cmd;
               rpt_cnt_d = 8'd0;
               vld_d     = 1'b1;
               tmr_d     = TMO_LD;
               state_d   = HELD;
            end
         end
         HELD: begin
            // a good frame always wins over the terminal count
            if (frame_good) begin
               tmr_d = TMO_LD;
               if (same_key) begin
                  rpt_d = 1'b1;
                  if (rpt_cnt != 8'hFF) rpt_cnt_d = rpt_cnt + 8'd1;
               end else begin
                  addr_d    = f_addr;
                  cmd_d     = f_cmd;
                  rpt_cnt_d = 8'd0;
                  vld_d     = 1'b1;
               end
            end else if (tmr_tc) begin
               rel_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tmr_q    <= '0;
         key_addr <= 8'd0;
         key_cmd  <= 8'd0;
         key_vld  <= 1'b0;
         key_rpt  <= 1'b0;
         key_rel  <= 1'b0;
         rpt_cnt  <= 8'd0;
         err_cnt  <= 8'd0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         key_addr <= addr_d;
         key_cmd  <= cmd_d;
         key_vld  <= vld_d;
         key_rpt  <= rpt_d;
         key_rel  <= rel_d;
         rpt_cnt  <= rpt_cnt_d;
         err_cnt  <= err_cnt_d;
      end
   end

   assign key_hold = (state_q == HELD);

endmodule

// File: tb/tb_ir_key_filter.sv
// tb_ir_key_filter: two instances (address checked / unchecked) driven by the
// same frames and compared every cycle against a deadline-based key model.
module tb_ir_key_filter;

   localparam int TMO = 10;

   logic        clk;
   logic        rst_n;
   logic [31:0] ir_data;
   logic        ir_data_vld;

   logic [7:0] key_addr [2];
   logic [7:0] key_cmd  [2];
   logic       key_vld  [2];
   logic       key_rpt  [2];
   logic       key_rel  [2];
   logic       key_hold [2];
   logic [7:0] rpt_cnt  [2];
   logic [7:0] err_cnt  [2];

   int vectors;
   int miscompares;

   ir_key_filter #(.CLK_FREQ(1000), .HOLD_MS(10), .CHK_ADDR(1)) u_dut_chk (
      .clk(clk), .rst_n(rst_n), .ir_data(ir_data), .ir_data_vld(ir_data_vld),
      .key_addr(key_addr[0]), .key_cmd(key_cmd[0]), .key_vld(key_vld[0]),
      .key_rpt(key_rpt[0]), .key_rel(key_rel[0]), .key_hold(key_hold[0]),
      .rpt_cnt(rpt_cnt[0]), .err_cnt(err_cnt[0])
   );

   ir_key_filter #(.CLK_FREQ(1000), .HOLD_MS(10), .CHK_ADDR(0)) u_dut_ext (
      .clk(clk), .rst_n(rst_n), .ir_data(ir_data), .ir_data_vld(ir_data_vld),
      .key_addr(key_addr[1]), .key_cmd(key_cmd[1]), .key_vld(key_vld[1]),
      .key_rpt(key_rpt[1]), .key_rel(key_rel[1]), .key_hold(key_hold[1]),
      .rpt_cnt(rpt_cnt[1]), .err_cnt(err_cnt[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: a key is held until the edge TMO cycles after its last good frame
   int         cyc;
   logic       m_held [2];
   int         m_dl   [2];
   logic [7:0] m_addr [2];
   logic [7:0] m_cmd  [2];
   logic [7:0] m_rcnt [2];
   logic [7:0] m_ecnt [2];
   logic       m_vld  [2];
   logic       m_rpt  [2];
   logic       m_rel  [2];

   function automatic bit fgood(input logic [31:0] d, input bit chk);
      return (d[23:16] == ~d[31:24]) && (!chk || d[7:0] == ~d[15:8]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0;
         for (int i = 0; i < 2; i++) begin
            m_held[i] <= 1'b0; m_dl[i] <= 0;
            m_addr[i] <= 8'd0; m_cmd[i] <= 8'd0;
            m_rcnt[i] <= 8'd0; m_ecnt[i] <= 8'd0;
            m_vld[i] <= 1'b0; m_rpt[i] <= 1'b0; m_rel[i] <= 1'b0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int i = 0; i < 2; i++) begin
            m_vld[i] <= 1'b0; m_rpt[i] <= 1'b0; m_rel[i] <= 1'b0;
            if (ir_data_vld && fgood(ir_data, i == 0)) begin
               m_held[i] <= 1'b1;
               m_dl[i]   <= cyc + TMO;
               if (m_held[i] && ir_data[7:0] == m_addr[i] && ir_data[23:16] == m_cmd[i]) begin
                  m_rpt[i] <= 1'b1;
                  if (m_rcnt[i] != 8'hFF) m_rcnt[i] <= m_rcnt[i] + 8'd1;
               end else begin
                  m_vld[i]  <= 1'b1;
                  m_addr[i] <= ir_data[7:0];
                  m_cmd[i]  <= ir_data[23:16];
                  m_rcnt[i] <= 8'd0;
               end
            end else begin
               if (ir_data_vld && m_ecnt[i] != 8'hFF) m_ecnt[i] <= m_ecnt[i] + 8'd1;
               if (m_held[i] && cyc == m_dl[i]) begin
                  m_rel[i]  <= 1'b1;
                  m_held[i] <= 1'b0;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("key_addr[%0d]", i), 32'(key_addr[i]), 32'(m_addr[i]));
         chk($sformatf("key_cmd[%0d]", i),  32'(key_cmd[i]),  32'(m_cmd[i]));
         chk($sformatf("key_vld[%0d]", i),  32'(key_vld[i]),  32'(m_vld[i]));
         chk($sformatf("key_rpt[%0d]", i),  32'(key_rpt[i]),  32'(m_rpt[i]));
         chk($sformatf("key_rel[%0d]", i),  32'(key_rel[i]),  32'(m_rel[i]));
         chk($sformatf("key_hold[%0d]", i), 32'(key_hold[i]), 32'(m_held[i]));
         chk($sformatf("rpt_cnt[%0d]", i),  32'(rpt_cnt[i]),  32'(m_rcnt[i]));
         chk($sformatf("err_cnt[%0d]", i),  32'(err_cnt[i]),  32'(m_ecnt[i]));
      end
   end

   // called at a falling edge; the frame is sampled on the next rising edge
   task automatic send(input logic [31:0] d);
      ir_data     = d;
      ir_data_vld = 1'b1;
      @(negedge clk);
      ir_data_vld = 1'b0;
      ir_data     = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst key_addr", 32'(key_addr[0]), 32'h0);
      chk("rst key_cmd",  32'(key_cmd[0]),  32'h0);
      chk("rst key_hold", 32'(key_hold[0]), 32'h0);
      chk("rst rpt_cnt",  32'(rpt_cnt[0]),  32'h0);
      chk("rst err_cnt",  32'(err_cnt[1]),  32'h0);
      chk("rst pulses",   32'({key_vld[0], key_rpt[0], key_rel[0]}), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_frame();
      logic [7:0] a, c, na, nc;
      a  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h34;
      c  = ($urandom_range(0, 1) == 0) ? 8'h1A : 8'h40;
      na = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~a;
      nc = ($urandom_range(0, 7) == 0) ? (~c ^ 8'h01) : ~c;
      return {nc, c, na, a};
   endfunction

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      ir_data     = 32'h0;
      ir_data_vld = 1'b0;
      @(negedge clk);
      pulse_reset();

      // single press then release after the hold timeout
      send(32'hE51A_FF00);
      chk("single key_vld",  32'(key_vld[0]),  32'h1);
      chk("single key_addr", 32'(key_addr[0]), 32'h00);
      chk("single key_cmd",  32'(key_cmd[0]),  32'h1A);
      chk("single key_hold", 32'(key_hold[0]), 32'h1);
      idle(9);
      chk("single no early rel", 32'(key_rel[0]), 32'h0);
      idle(1);
      chk("single key_rel",  32'(key_rel[0]),  32'h1);
      chk("single hold off", 32'(key_hold[0]), 32'h0);
      idle(2);

      // press plus three repeats at 5-cycle spacing
      send(32'hE51A_FF00);
      for (int r = 0; r < 3; r++) begin
         idle(4);
         send(32'hE51A_FF00);
         chk("repeat key_rpt", 32'(key_rpt[0]), 32'h1);
      end
      chk("repeat rpt_cnt", 32'(rpt_cnt[0]), 32'h3);
      idle(9);
      chk("repeat no early rel", 32'(key_rel[0]), 32'h0);
      idle(1);
      chk("repeat key_rel", 32'(key_rel[0]), 32'h1);
      idle(2);

      // different key while held
      send(32'hE51A_FF00);
      idle(3);
      send(32'hBF40_FF00);
      chk("change key_vld", 32'(key_vld[0]), 32'h1);
      chk("change key_cmd", 32'(key_cmd[0]), 32'h40);
      chk("change rpt_cnt", 32'(rpt_cnt[0]), 32'h0);
      idle(12);

      // repeat landing on the terminal-count cycle, then reset while held
      send(32'hE51A_FF00);
      idle(9);
      send(32'hE51A_FF00);
      chk("tc key_rpt", 32'(key_rpt[0]), 32'h1);
      chk("tc key_rel", 32'(key_rel[0]), 32'h0);
      pulse_reset();
      idle(15);
      chk("post-rst key_hold", 32'(key_hold[0]), 32'h0);
      chk("post-rst key_rel",  32'(key_rel[0]),  32'h0);

      // bad frames and unchecked-address frames
      send(32'hE51B_FF00);
      chk("bad err_cnt", 32'(err_cnt[0]), 32'h1);
      chk("bad no vld",  32'(key_vld[0]), 32'h0);
      send(32'hE51A_1234);
      chk("ext key_vld",  32'(key_vld[1]),  32'h1);
      chk("ext key_addr", 32'(key_addr[1]), 32'h34);
      chk("chk err_cnt",  32'(err_cnt[0]),  32'h2);
      for (int b = 0; b < 300; b++) send(32'hE51B_FF00);
      chk("sat err_cnt chk", 32'(err_cnt[0]), 32'hFF);
      chk("sat err_cnt ext", 32'(err_cnt[1]), 32'hFF);
      idle(12);

      // randomized frames with gaps around the hold timeout
      for (int k = 0; k < 400; k++) begin
         if (k == 200) pulse_reset();
         send(rand_frame());
         idle($urandom_range(0, 13));
      end
      idle(15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
